nx_indirect_access_initiator: RTL and testbench

Hardware-side master for the indirect-access register protocol used by the NX memory wrappers (2RW/1RW RAM indirect access). It accepts simple read/write/init requests on a valid/ready interface and turns each one into the register sequence: optional data-register write, command-register write, then status polling. It returns the final status and read data on a response handshake. It sits between an on-chip agent (BIST sequencer, config loader) and the `reg_addr`/`wr_stb`/`wr_dat`/`cmnd_op`/`stat_code`/`rd_dat` pins of one memory wrapper.

---
 rtl/nx_indirect_access_initiator.sv | 193 +++++++++++++++++++
 tb/tb_nx_indirect_access_initiator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_indirect_access_initiator.sv
`timescale 1ns/1ps
// Indirect-access initiator: converts read/write/init requests into the
// data-write / command-write / status-poll register sequence of an NX memory wrapper.
module nx_indirect_access_initiator #(
    parameter int unsigned CMND_ADDRESS    = 0,
    parameter int unsigned DATA_ADDRESS    = 4,
    parameter int unsigned N_REG_ADDR_BITS = 16,
    parameter int unsigned N_DATA_BITS     = 32,
    parameter int unsigned N_ENTRIES       = 1,
    parameter int unsigned N_POLL_BITS     = 8,
    localparam int unsigned AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [AW-1:0]              req_addr,
    input  logic [N_DATA_BITS-1:0]     req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2:0]                 rsp_code,
    output logic [N_DATA_BITS-1:0]     rsp_rdata,
    output logic [N_REG_ADDR_BITS-1:0] reg_addr,
    output logic                       wr_stb,
    output logic [N_DATA_BITS-1:0]     wr_dat,
    output logic [3:0]                 cmnd_op,
    output logic [AW-1:0]              cmnd_addr,
    input  logic [2:0]                 stat_code,
    input  logic [AW-1:0]              stat_addr,
    input  logic [N_DATA_BITS-1:0]     rd_dat
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_CMND   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_POLL   = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [2:0] STAT_RDY  = 3'd0;
    localparam logic [2:0] STAT_BSY  = 3'd1;
    localparam logic [2:0] CODE_NAK  = 3'd4;
    localparam logic [2:0] CODE_AMIS = 3'd6;
    localparam logic [2:0] CODE_LTMO = 3'd7;

    localparam logic [AW:0] MAX_ADDR = (AW + 1)'(N_ENTRIES - 1);
    localparam logic [N_REG_ADDR_BITS-1:0] CMND_REG = N_REG_ADDR_BITS'(CMND_ADDRESS);
    localparam logic [N_REG_ADDR_BITS-1:0] DATA_REG = N_REG_ADDR_BITS'(DATA_ADDRESS);

    logic [2:0]                 state_reg, state_next;
    logic [1:0]                 op_reg, op_next;
    logic [AW-1:0]              addr_reg, addr_next;
    logic [N_POLL_BITS-1:0]     poll_cnt_reg, poll_cnt_next;
    logic [N_POLL_BITS-1:0]     poll_inc;
    logic [2:0]                 rsp_code_reg, rsp_code_next;
    logic [N_DATA_BITS-1:0]     rsp_rdata_reg, rsp_rdata_next;
    logic                       wr_stb_reg, wr_stb_next;
    logic [N_REG_ADDR_BITS-1:0] reg_addr_reg, reg_addr_next;
    logic [N_DATA_BITS-1:0]     wr_dat_reg, wr_dat_next;
    logic [3:0]                 cmnd_op_reg, cmnd_op_next;
    logic [AW-1:0]              cmnd_addr_reg, cmnd_addr_next;
    logic                       addr_bad;
    logic [2:0]                 final_code;

    assign addr_bad = ({1'b0, req_addr} > MAX_ADDR);
    assign poll_inc = poll_cnt_reg + 1'b1;

    // A ready status only counts if it refers to the entry we commanded.
    assign final_code = (stat_code == STAT_RDY && stat_addr != addr_reg) ? CODE_AMIS : stat_code;

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        addr_next      = addr_reg;
        poll_cnt_next  = poll_cnt_reg;
        rsp_code_next  = rsp_code_reg;
        rsp_rdata_next = rsp_rdata_reg;
        wr_stb_next    = 1'b0;
        reg_addr_next  = '0;
        wr_dat_next    = '0;
        cmnd_op_next   = '0;
        cmnd_addr_next = '0;

        // Register-side outputs are loaded on entry to DATA/CMND so they
        // appear registered in exactly the cycle the state is occupied.
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    op_next        = req_op;
                    addr_next      = req_addr;
                    rsp_rdata_next = '0;
                    rsp_code_next  = STAT_RDY;
                    if (req_op == OP_RSVD || addr_bad) begin
                        rsp_code_next = CODE_NAK;
                        state_next    = ST_RESP;
                    end else if (req_op == OP_WRITE) begin
                        wr_stb_next   = 1'b1;
                        reg_addr_next = DATA_REG;
                        wr_dat_next   = req_wdata;
                        state_next    = ST_DATA;
                    end else begin
                        wr_stb_next    = 1'b1;
                        reg_addr_next  = CMND_REG;
                        cmnd_op_next   = {2'b00, req_op} + 4'd1;
                        cmnd_addr_next = req_addr;
                        state_next     = ST_CMND;
                    end
                end
            end
            ST_DATA: begin
                wr_stb_next    = 1'b1;
                reg_addr_next  = CMND_REG;
                cmnd_op_next   = {2'b00, op_reg} + 4'd1;
                cmnd_addr_next = addr_reg;
                state_next     = ST_CMND;
            end
            ST_CMND: begin
                poll_cnt_next = '0;
                state_next    = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_next = ST_POLL;
            end
            ST_POLL: begin
                if (stat_code == STAT_BSY) begin
                    poll_cnt_next = poll_inc;
                    if (poll_inc == '1) begin
                        rsp_code_next = CODE_LTMO;
                        state_next    = ST_RESP;
                    end
                end else begin
                    rsp_code_next = final_code;
                    if (op_reg == OP_READ && final_code == STAT_RDY) begin
                        rsp_rdata_next = rd_dat;
                    end
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            addr_reg      <= '0;
            poll_cnt_reg  <= '0;
            rsp_code_reg  <= '0;
            rsp_rdata_reg <= '0;
            wr_stb_reg    <= 1'b0;
            reg_addr_reg  <= '0;
            wr_dat_reg    <= '0;
            cmnd_op_reg   <= '0;
            cmnd_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            addr_reg      <= addr_next;
            poll_cnt_reg  <= poll_cnt_next;
            rsp_code_reg  <= rsp_code_next;
            rsp_rdata_reg <= rsp_rdata_next;
            wr_stb_reg    <= wr_stb_next;
            reg_addr_reg  <= reg_addr_next;
            wr_dat_reg    <= wr_dat_next;
            cmnd_op_reg   <= cmnd_op_next;
            cmnd_addr_reg <= cmnd_addr_next;
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_code  = rsp_code_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign wr_stb    = wr_stb_reg;
    assign reg_addr  = reg_addr_reg;
    assign wr_dat    = wr_dat_reg;
    assign cmnd_op   = cmnd_op_reg;
    assign cmnd_addr = cmnd_addr_reg;

endmodule

// File: tb/tb_nx_indirect_access_initiator.sv
`timescale 1ns/1ps
// Directed + randomized bench: a per-transaction timeline model derived from the
// protocol rules predicts strobes, poll window, completion cycle and response.
module tb_nx_indirect_access_initiator;

    localparam int AW        = 4;
    localparam int DW        = 32;
    localparam int NENT      = 12;
    localparam int POLL_LIM  = 15;
    localparam int DATA_ADDR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [2:0]    rsp_code;
    logic [DW-1:0] rsp_rdata;
    logic [15:0]   reg_addr;
    logic          wr_stb;
    logic [DW-1:0] wr_dat;
    logic [3:0]    cmnd_op;
    logic [AW-1:0] cmnd_addr;
    logic [2:0]    stat_code;
    logic [AW-1:0] stat_addr;
    logic [DW-1:0] rd_dat;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nx_indirect_access_initiator #(
        .CMND_ADDRESS(0),
        .DATA_ADDRESS(DATA_ADDR),
        .N_REG_ADDR_BITS(16),
        .N_DATA_BITS(DW),
        .N_ENTRIES(NENT),
        .N_POLL_BITS(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_code(rsp_code),
        .rsp_rdata(rsp_rdata),
        .reg_addr(reg_addr),
        .wr_stb(wr_stb),
        .wr_dat(wr_dat),
        .cmnd_op(cmnd_op),
        .cmnd_addr(cmnd_addr),
        .stat_code(stat_code),
        .stat_addr(stat_addr),
        .rd_dat(rd_dat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] idle_stat();
        int t;
        t = $urandom_range(0, 2);
        return (t == 0) ? 3'd0 : ((t == 1) ? 3'd2 : 3'd3);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_code"}, rsp_code, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_wr_stb"}, wr_stb, 0);
        chk({tag, "_reg_addr"}, reg_addr, 0);
        chk({tag, "_wr_dat"}, wr_dat, 0);
        chk({tag, "_cmnd_op"}, cmnd_op, 0);
        chk({tag, "_cmnd_addr"}, cmnd_addr, 0);
    endtask

    // Called at a falling edge in a cycle where the DUT should be idle.
    // nb = BSY samples before the final status; abort_k > 0 pulls reset at that cycle.
    task automatic run_txn(input string tag, input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int nb, input logic [2:0] fin,
                           input logic [AW-1:0] saddr, input logic [DW-1:0] rdat,
                           input int dly, input int abort_k);
        bit            nak;
        bit            is_wr;
        int            cmd_k, ps, resp_k, j;
        logic [2:0]    ecode;
        logic [DW-1:0] erd;
        bit            stb_e;
        logic [15:0]   ra_e;
        logic [DW-1:0] wd_e;
        logic [3:0]    op_e;
        logic [AW-1:0] ca_e;

        nak   = (op == 2'd3) || (int'(addr) > NENT - 1);
        is_wr = (op == 2'd1);
        cmd_k = is_wr ? 2 : 1;
        ps    = cmd_k + 2;
        if (nak) begin
            resp_k = 1; ecode = 3'd4; erd = '0;
        end else if (nb >= POLL_LIM) begin
            resp_k = ps + POLL_LIM; ecode = 3'd7; erd = '0;
        end else begin
            resp_k = ps + nb + 1;
            ecode  = (fin == 3'd0 && saddr != addr) ? 3'd6 : fin;
            erd    = (op == 2'd0 && ecode == 3'd0) ? rdat : '0;
        end

        chk({tag, "_req_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        stat_code = idle_stat();
        stat_addr = AW'($urandom);
        rd_dat    = $urandom;
        rsp_ready = 1'($urandom);

        for (int k = 1; k <= resp_k; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_op    = 2'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = $urandom;
            if (k == abort_k) begin
                rst_n     = 1'b0;
                rsp_ready = 1'b0;
                return;
            end
            if (!nak && k >= ps) begin
                j = k - ps;
                if (j < nb) begin
                    stat_code = 3'd1;
                    stat_addr = AW'($urandom);
                    rd_dat    = $urandom;
                end else begin
                    stat_code = fin;
                    stat_addr = saddr;
                    rd_dat    = rdat;
                end
            end else begin
                stat_code = idle_stat();
                stat_addr = AW'($urandom);
                rd_dat    = $urandom;
            end
            if (k < resp_k) begin
                stb_e = !nak && (k == cmd_k || (is_wr && k == 1));
                ra_e  = (!nak && is_wr && k == 1) ? 16'(DATA_ADDR) : 16'd0;
                wd_e  = (!nak && is_wr && k == 1) ? wdata : '0;
                op_e  = (!nak && k == cmd_k) ? ({2'b00, op} + 4'd1) : 4'd0;
                ca_e  = (!nak && k == cmd_k) ? addr : '0;
                chk($sformatf("%s_c%0d_rsp_valid", tag, k), rsp_valid, 0);
                chk($sformatf("%s_c%0d_req_ready", tag, k), req_ready, 0);
                chk($sformatf("%s_c%0d_wr_stb", tag, k), wr_stb, stb_e);
                chk($sformatf("%s_c%0d_reg_addr", tag, k), reg_addr, ra_e);
                chk($sformatf("%s_c%0d_wr_dat", tag, k), wr_dat, wd_e);
                chk($sformatf("%s_c%0d_cmnd_op", tag, k), cmnd_op, op_e);
                chk($sformatf("%s_c%0d_cmnd_addr", tag, k), cmnd_addr, ca_e);
                chk($sformatf("%s_c%0d_rsp_rdata", tag, k), rsp_rdata, 0);
                rsp_ready = 1'($urandom);
            end else begin
                chk({tag, "_rsp_valid"}, rsp_valid, 1);
                chk({tag, "_rsp_code"}, rsp_code, ecode);
                chk({tag, "_rsp_rdata"}, rsp_rdata, erd);
                chk({tag, "_resp_wr_stb"}, wr_stb, 0);
                chk({tag, "_resp_req_ready"}, req_ready, 0);
                rsp_ready = (dly == 0);
            end
        end

        for (int d = 1; d <= dly; d++) begin
            @(negedge clk);
            chk($sformatf("%s_hold%0d_valid", tag, d), rsp_valid, 1);
            chk($sformatf("%s_hold%0d_code", tag, d), rsp_code, ecode);
            chk($sformatf("%s_hold%0d_rdata", tag, d), rsp_rdata, erd);
            chk($sformatf("%s_hold%0d_req_ready", tag, d), req_ready, 0);
            chk($sformatf("%s_hold%0d_wr_stb", tag, d), wr_stb, 0);
            rsp_ready = (d == dly);
        end

        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_done_rsp_valid"}, rsp_valid, 0);
        $display("txn %s op=%0d addr=%0d nb=%0d code=%0d rdata=%08h", tag, op, addr, nb, ecode, erd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    r_op;
        logic [AW-1:0] r_addr, r_saddr;
        logic [2:0]    r_fin;
        int            r_nb, t;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        stat_code = '0;
        stat_addr = '0;
        rd_dat    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        run_txn("rd_bsy3", 2'd0, 4'd5, 32'h0, 3, 3'd0, 4'd5, 32'hDEADBEEF, 0, 0);
        run_txn("wr_basic", 2'd1, 4'd2, 32'h12345678, 2, 3'd0, 4'd2, 32'hCAFEF00D, 1, 0);
        run_txn("rd_oob", 2'd0, 4'd12, 32'h0, 0, 3'd0, 4'd12, 32'h11111111, 0, 0);
        run_txn("rsvd_op", 2'd3, 4'd1, 32'h0, 0, 3'd0, 4'd1, 32'h22222222, 2, 0);
        run_txn("rd_last", 2'd0, 4'd11, 32'h0, 0, 3'd0, 4'd11, 32'hA5A5A5A5, 0, 0);
        run_txn("rd_tmo", 2'd0, 4'd3, 32'h0, 40, 3'd0, 4'd3, 32'h33333333, 0, 0);
        run_txn("rd_bsy14", 2'd0, 4'd3, 32'h0, 14, 3'd0, 4'd3, 32'h44444444, 0, 0);
        run_txn("init_tmo", 2'd2, 4'd6, 32'h0, 15, 3'd0, 4'd6, 32'h55555555, 1, 0);
        run_txn("rd_amis", 2'd0, 4'd4, 32'h0, 1, 3'd0, 4'd3, 32'h66666666, 0, 0);
        run_txn("wr_err", 2'd1, 4'd7, 32'h0BADF00D, 0, 3'd3, 4'd7, 32'h77777777, 0, 0);
        run_txn("init_ctmo", 2'd2, 4'd0, 32'h0, 2, 3'd2, 4'd0, 32'h88888888, 0, 0);

        run_txn("rd_abort", 2'd0, 4'd1, 32'h0, 10, 3'd0, 4'd1, 32'h99999999, 0, 5);
        @(negedge clk);
        chk_reset("abort");
        rst_n = 1'b1;
        run_txn("rd_after_rst", 2'd0, 4'd9, 32'h0, 0, 3'd0, 4'd9, 32'h13579BDF, 0, 0);
        run_txn("rd_hold10", 2'd0, 4'd8, 32'h0, 1, 3'd0, 4'd8, 32'h2468ACE0, 10, 0);

        for (int i = 0; i < 40; i++) begin
            r_op   = 2'($urandom);
            r_addr = 4'($urandom_range(0, NENT + 1));
            t      = $urandom_range(0, 9);
            r_nb   = (t == 0) ? $urandom_range(14, 17) : $urandom_range(0, 5);
            t      = $urandom_range(0, 2);
            r_fin  = (t == 0) ? 3'd0 : ((t == 1) ? 3'd2 : 3'd3);
            r_saddr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : r_addr;
            run_txn($sformatf("rnd%0d", i), r_op, r_addr, $urandom, r_nb, r_fin, r_saddr,
                    $urandom, $urandom_range(0, 3), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
